// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage forwarding, load-use detection and mul/div sequencing.
// Forwarding and stall/flush outputs are decoded from the current state and inputs each cycle.
module ex_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MULDIV_CYCLES  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
  input  logic                      memread_ex,
  input  logic                      muldiv_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rd_mem,
  input  logic                      regwrite_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_wb,
  input  logic                      regwrite_wb,
  input  logic                      kill,
  output logic [1:0]                forwarda,
  output logic [1:0]                forwardb,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      flush_ex,
  output logic                      bubble_mem,
  output logic                      muldiv_start,
  output logic                      muldiv_busy,
  output logic                      muldiv_result_sel
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b, load_use;

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    mem_hit_a = regwrite_mem && (rd_mem != REG_ZERO) && (rd_mem == rs1_ex);
    mem_hit_b = regwrite_mem && (rd_mem != REG_ZERO) && (rd_mem == rs2_ex);
    wb_hit_a  = regwrite_wb  && (rd_wb  != REG_ZERO) && (rd_wb  == rs1_ex);
    wb_hit_b  = regwrite_wb  && (rd_wb  != REG_ZERO) && (rd_wb  == rs2_ex);
    forwarda  = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
    forwardb  = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);
    load_use  = memread_ex && (rd_ex != REG_ZERO) &&
                ((rd_ex == rs1_id) || (rd_ex == rs2_id));
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    stall_ex          = 1'b0;
    flush_ex          = 1'b0;
    bubble_mem        = 1'b0;
    muldiv_start      = 1'b0;
    muldiv_busy       = 1'b0;
    muldiv_result_sel = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (muldiv_ex && !kill) begin
          muldiv_start = 1'b1;
          stall_if     = 1'b1;
          stall_id     = 1'b1;
          stall_ex     = 1'b1;
          bubble_mem   = 1'b1;
          cnt_d        = CNT_LOAD;
          state_d      = ST_RUN;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      ST_RUN: begin
        muldiv_busy = 1'b1;
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        stall_ex    = 1'b1;
        bubble_mem  = 1'b1;
        cnt_d       = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        muldiv_result_sel = !kill;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // A kill abandons any sequence; stalls above still cover the kill cycle itself.
    if (kill) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed self-checking bench for ex_hazard_ctrl.
// ctrl vector = {stall_if, stall_id, stall_ex, flush_ex, bubble_mem, muldiv_start, muldiv_busy, muldiv_result_sel}.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic       memread_ex, muldiv_ex, regwrite_mem, regwrite_wb, kill;
  logic [1:0] forwarda, forwardb;
  logic       stall_if, stall_id, stall_ex, flush_ex, bubble_mem;
  logic       muldiv_start, muldiv_busy, muldiv_result_sel;
  logic [7:0] ctrl;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_LU    = 8'hD0;
  localparam logic [7:0] C_START = 8'hEC;
  localparam logic [7:0] C_RUN   = 8'hEA;
  localparam logic [7:0] C_DONE  = 8'h01;

  ex_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .memread_ex(memread_ex), .muldiv_ex(muldiv_ex),
    .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
    .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .kill(kill),
    .forwarda(forwarda), .forwardb(forwardb),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .bubble_mem(bubble_mem),
    .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
    .muldiv_result_sel(muldiv_result_sel)
  );

  always #5 clk = ~clk;

  assign ctrl = {stall_if, stall_id, stall_ex, flush_ex, bubble_mem,
                 muldiv_start, muldiv_busy, muldiv_result_sel};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0;
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    memread_ex = 0; muldiv_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    #1;
    chk("reset_ctrl", ctrl, C_IDLE);
    chk("reset_fwda", {6'd0, forwarda}, 8'h00);
    chk("reset_fwdb", {6'd0, forwardb}, 8'h00);

    next_cycle();
    rs1_ex = 5; rs2_ex = 5; rd_mem = 5; rd_wb = 5; regwrite_mem = 1; regwrite_wb = 1;
    #1;
    chk("fwd_mem_a", {6'd0, forwarda}, 8'h02);
    chk("fwd_mem_b", {6'd0, forwardb}, 8'h02);
    regwrite_mem = 0;
    #1;
    chk("fwd_wb_a", {6'd0, forwarda}, 8'h01);
    regwrite_mem = 1; rd_mem = 6;
    #1;
    chk("fwd_wb_a_mem_miss", {6'd0, forwarda}, 8'h01);
    rs1_ex = 0; rd_mem = 0; rd_wb = 0;
    #1;
    chk("fwd_zero_a", {6'd0, forwarda}, 8'h00);
    rs2_ex = 9; rd_mem = 9; regwrite_mem = 0; rd_wb = 9;
    #1;
    chk("fwd_wb_b", {6'd0, forwardb}, 8'h01);
    regwrite_wb = 0;
    #1;
    chk("fwd_none_b", {6'd0, forwardb}, 8'h00);

    next_cycle();
    memread_ex = 1; rd_ex = 7; rs2_id = 7;
    #1;
    chk("load_use_rs2", ctrl, C_LU);
    next_cycle();
    memread_ex = 0; rd_ex = 0; rs2_id = 0;
    #1;
    chk("load_use_one_cycle", ctrl, C_IDLE);
    next_cycle();
    memread_ex = 1; rd_ex = 0; rs1_id = 0;
    #1;
    chk("load_use_rd0", ctrl, C_IDLE);
    next_cycle();
    rd_ex = 3; rs1_id = 3;
    #1;
    chk("load_use_rs1", ctrl, C_LU);
    next_cycle();
    memread_ex = 0; rd_ex = 0; rs1_id = 0;

    next_cycle();
    muldiv_ex = 1;
    #1;
    chk("md_start", ctrl, C_START);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk("md_run", ctrl, C_RUN);
    end
    next_cycle(); #1;
    chk("md_done", ctrl, C_DONE);
    next_cycle(); #1;
    chk("md_restart", ctrl, C_START);
    next_cycle(); #1;
    chk("kill_run1", ctrl, C_RUN);
    next_cycle();
    kill = 1;
    #1;
    chk("kill_run2", ctrl, C_RUN);
    next_cycle();
    kill = 0; muldiv_ex = 0;
    #1;
    chk("kill_after1", ctrl, C_IDLE);
    next_cycle(); #1;
    chk("kill_after2", ctrl, C_IDLE);

    next_cycle();
    kill = 1; muldiv_ex = 1;
    #1;
    chk("kill_start_suppr", ctrl, C_IDLE);
    next_cycle();
    kill = 0; muldiv_ex = 0;
    #1;
    chk("kill_idle_after", ctrl, C_IDLE);

    next_cycle();
    muldiv_ex = 1; memread_ex = 1; rd_ex = 7; rs1_id = 7;
    #1;
    chk("coll_start", ctrl, C_START);
    next_cycle(); #1;
    chk("coll_run", ctrl, C_RUN);
    next_cycle();
    rst = 1; muldiv_ex = 0; memread_ex = 0; rd_ex = 0; rs1_id = 0;
    next_cycle();
    rst = 0;
    #1;
    chk("rst_mid_run", ctrl, C_IDLE);
    next_cycle();
    muldiv_ex = 1;
    #1;
    chk("rst_fresh_start", ctrl, C_START);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk("rst_fresh_run", ctrl, C_RUN);
    end
    next_cycle();
    muldiv_ex = 0;
    #1;
    chk("rst_fresh_done", ctrl, C_DONE);
    next_cycle(); #1;
    chk("rst_fresh_idle", ctrl, C_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

EX-stage hazard and sequencing controller for the 5-stage RV32 pipeline. It generates the `forwarda`/`forwardb` selects that drive the EX operand multiplexers and detects load-use hazards. It also sequences the multi-cycle mul/div unit that shares the EX stage, stalling IF/ID/EX and bubbling MEM while an iterative operation runs. It sits beside the EX operand mux and takes register indices and write-enables from the ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- `REG_ADDR_WIDTH`, 5, register index width.
- `MULDIV_CYCLES`, 32, iteration count of the mul/div unit; legal range 2..255.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs1_id`, `rs2_id`  in  REG_ADDR_WIDTH  source indices of the instruction in ID.
- `rs1_ex`, `rs2_ex`  in  REG_ADDR_WIDTH  source indices of the instruction in EX.
- `rd_ex`  in  REG_ADDR_WIDTH  destination index in EX.
- `memread_ex`  in  1  EX instruction is a load.
- `muldiv_ex`  in  1  EX instruction is a mul/div op.
- `rd_mem`, `regwrite_mem`  in  REG_ADDR_WIDTH, 1  EX/MEM destination and write enable.
- `rd_wb`, `regwrite_wb`  in  REG_ADDR_WIDTH, 1  MEM/WB destination and write enable.
- `kill`  in  1  trap/redirect; squashes EX and younger.
- `forwarda`, `forwardb`  out  2  operand select: 00 = regfile, 10 = MEM, 01 = WB; 11 is never driven.
- `stall_if`, `stall_id`, `stall_ex`  out  1  hold the PC, IF/ID and ID/EX registers.
- `flush_ex`  out  1  load bubble into ID/EX.
- `bubble_mem`  out  1  write a NOP into EX/MEM.
- `muldiv_start`  out  1  one-cycle start pulse to the mul/div unit; it latches the forwarded operands on this cycle.
- `muldiv_busy`  out  1  sequence in progress.
- `muldiv_result_sel`  out  1  EX result comes from mul/div (DONE cycle only).

## Operation
- **Forwarding** is combinational and valid in every state.
  - `forwarda` = 10 if `regwrite_mem` && `rd_mem`!=0 && `rd_mem`==`rs1_ex`.
  - Otherwise `forwarda` = 01 if `regwrite_wb` && `rd_wb`!=0 && `rd_wb`==`rs1_ex`.
  - Otherwise `forwarda` = 00.
  - `forwardb` is identical using `rs2_ex`.
  - MEM beats WB. Index 0 is never forwarded.
- **Load-use** condition: `memread_ex` && `rd_ex`!=0 && (`rd_ex`==`rs1_id` || `rd_ex`==`rs2_id`).
  - Evaluated only in IDLE.
  - Asserts `stall_if`=`stall_id`=`flush_ex`=1 for that cycle.
- **FSM** states: IDLE, RUN, DONE. Down-counter `cnt` is 8 bits.
  - IDLE→RUN when `muldiv_ex` && !`kill`. In that cycle: `muldiv_start`=1, `cnt` loads MULDIV_CYCLES-1, stalls and `bubble_mem` asserted.
  - RUN: `muldiv_busy`=1; `stall_if`/`stall_id`/`stall_ex`=1; `bubble_mem`=1; `cnt` decrements. When `cnt`==1, go to DONE.
  - DONE: `muldiv_result_sel`=1; all stalls and bubble deasserted; EX/MEM captures the result. Go to IDLE unconditionally.
- **Kill** in any state: next state is IDLE, `cnt` is cleared, and `muldiv_start` is suppressed that cycle. Stalls are still driven combinationally for the kill cycle if the FSM is in RUN.
- **Priority**: RUN/start stalls over load-use. `flush_ex` is never asserted outside IDLE.
- `muldiv_ex` is not re-sampled in DONE, so back-to-back mul/div gets a fresh start in the following IDLE cycle.

## Timing
- Reset values: state = IDLE, `cnt` = 0. All outputs 0, except that `forwarda`/`forwardb` are combinational and read 00 while all enables are low.
- Mul/div occupancy: start cycle, then MULDIV_CYCLES-1 RUN cycles, then 1 DONE cycle, for MULDIV_CYCLES+1 cycles total. Stalls are high for the first MULDIV_CYCLES of those cycles.
- Load-use costs exactly 1 bubble. The next cycle re-evaluates with the load in MEM, so forwarding from MEM is not valid for the load. The WB path resolves it one cycle later through the normal pipeline advance.
- Forwarding selects depend only on current-cycle inputs, with zero latency.
- `rst` asserted mid-sequence returns to IDLE on the next edge; no DONE cycle occurs.

## Test plan
- **Forward priority**: `rs1_ex`=5, `rd_mem`=5, `rd_wb`=5, both regwrites=1 → `forwarda`=10. Drop `regwrite_mem` → 01. Set `rd_mem`=`rd_wb`=0 with `rs1_ex`=0 → 00.
- **Load-use**: `memread_ex`=1, `rd_ex`=7, `rs2_id`=7 → exactly one cycle of `stall_if`/`stall_id`/`flush_ex`=1. With `rd_ex`=0 → no stall.
- **Mul/div with MULDIV_CYCLES=4**: `muldiv_ex`=1 → `muldiv_start` for 1 cycle, `stall_ex`=1 for 4 cycles, `muldiv_result_sel`=1 on cycle 5, IDLE on cycle 6.
- **Kill mid-RUN**: assert `kill` on the 2nd RUN cycle → IDLE on the next edge, no `muldiv_result_sel` pulse, stalls low afterwards.
- **Collision**: load-use condition true while the FSM is in RUN → `flush_ex` stays 0 and only the mul/div stalls are asserted.
- **Reset mid-RUN**: `rst`=1 for 1 cycle → all outputs 0 and state IDLE; a subsequent `muldiv_ex` starts a fresh 5-cycle sequence.
